// File: rtl/program_loader.sv
// Streams host bytes into the 16x8 program RAM from address 0, holding the CPU in reset meanwhile.
// Optional readback verify of the written image is enabled by PROGRAM_LOADER_READBACK_EN.
module program_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {StIdle, StLoad, StFinish, StVerify} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              xfer;

`ifdef PROGRAM_LOADER_READBACK_EN
    // One extra bit: the verify step counter runs up to last+2.
    logic [ADDR_W:0]   vcnt_q, vcnt_d;
    logic [ADDR_W:0]   last_ext;
    logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
    logic              err_q, err_d;
    logic              mismatch;

    assign last_ext = {1'b0, last_q};
    assign mismatch = (rd_sum_q != checksum_q);
    assign err      = err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign err          = 1'b0;
`endif

    assign xfer = (state_q == StLoad) && in_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (xfer && (addr_q == last_q)) begin
`ifdef PROGRAM_LOADER_READBACK_EN
                    state_d = StVerify;
`else
                    state_d = StFinish;
`endif
                end
            end
            StFinish: state_d = StIdle;
            StVerify: begin
`ifdef PROGRAM_LOADER_READBACK_EN
                if (vcnt_q == last_ext + (ADDR_W + 1)'(2)) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        last_d      = last_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        checksum_d  = checksum_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef PROGRAM_LOADER_READBACK_EN
        vcnt_d      = vcnt_q;
        rd_sum_d    = rd_sum_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    last_d      = len;
                    addr_d      = '0;
                    checksum_d  = '0;
                    cpu_reset_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef PROGRAM_LOADER_READBACK_EN
                    vcnt_d      = '0;
                    rd_sum_d    = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            StLoad: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    checksum_d  = checksum_q + in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                end
            end
            StFinish: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
`ifdef PROGRAM_LOADER_READBACK_EN
                cpu_reset_d = err_q;
`else
                cpu_reset_d = 1'b0;
`endif
            end
            StVerify: begin
`ifdef PROGRAM_LOADER_READBACK_EN
                // Step j drives address j and accumulates rdata of address j-1.
                vcnt_d = vcnt_q + (ADDR_W + 1)'(1);
                if (vcnt_q <= last_ext) mem_addr_d = vcnt_q[ADDR_W-1:0];
                if ((vcnt_q != '0) && (vcnt_q <= last_ext + (ADDR_W + 1)'(1))) begin
                    rd_sum_d = rd_sum_q + mem_rdata;
                end
                if (vcnt_q == last_ext + (ADDR_W + 1)'(2)) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    err_d       = mismatch;
                    cpu_reset_d = mismatch;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            checksum_q  <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PROGRAM_LOADER_READBACK_EN
            vcnt_q      <= '0;
            rd_sum_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            last_q      <= last_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            checksum_q  <= checksum_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PROGRAM_LOADER_READBACK_EN
            vcnt_q      <= vcnt_d;
            rd_sum_q    <= rd_sum_d;
            err_q       <= err_d;
`endif
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == StLoad);
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        cpu_reset = cpu_reset_q;
        busy      = busy_q;
        done      = done_q;
        checksum  = checksum_q;
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a simple RAM model on the write/read port.
// Readback scenarios are compiled in only when PROGRAM_LOADER_READBACK_EN is defined.
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] checksum;

    int n_checks = 0;
    int n_err    = 0;
    int we_cnt   = 0;
    int done_cnt = 0;
    logic       corrupt = 1'b0;
    logic [7:0] ram [16];

    program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    assign mem_rdata = ram[mem_addr] ^ ((corrupt && mem_addr == 4'd2) ? 8'h01 : 8'h00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_cpu_reset", cpu_reset, 1);
        chk("start_in_ready", in_ready, 1);
    endtask

    logic [7:0] basic [4];
    int we_base;
    int done_base;

    initial begin
        basic[0] = 8'h86; basic[1] = 8'h45; basic[2] = 8'h21; basic[3] = 8'h97;
        reset = 1'b0; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0;

        // Asynchronous reset before the first clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_checksum", checksum, 0);
        tick();
        reset = 1'b0;
        in_valid = 1'b1;   // ignored in IDLE
        in_data  = 8'hEE;
        tick();
        chk("idle_ignore_we", mem_we, 0);
        chk("idle_ready", in_ready, 0);
        in_valid = 1'b0;

        // Basic back-to-back load
        we_base = we_cnt;
        do_start(4'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = basic[i];
            tick();
            chk("basic_we", mem_we, 1);
            chk("basic_addr", mem_addr, i);
            chk("basic_wdata", mem_wdata, basic[i]);
        end
        in_valid = 1'b0;
        chk("basic_fin_ready", in_ready, 0);
        chk("basic_fin_done", done, 0);
        chk("basic_fin_busy", busy, 1);
        tick();
        chk("basic_done", done, 1);
        chk("basic_busy", busy, 0);
        chk("basic_cpu_reset", cpu_reset, 0);
        chk("basic_we_low", mem_we, 0);
        chk("basic_checksum", checksum, 8'h83);
        chk("basic_we_cnt", we_cnt - we_base, 4);
        tick();
        chk("basic_done_pulse", done, 0);

        // Throttled host
        we_base = we_cnt;
        do_start(4'd2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'((i + 1) * 16);
            tick();
            chk("thr_we", mem_we, 1);
            chk("thr_addr", mem_addr, i);
            in_valid = 1'b0;
            if (i < 2) begin
                tick();
                chk("thr_idle_we", mem_we, 0);
            end
        end
        tick();
        chk("thr_done", done, 1);
        chk("thr_checksum", checksum, 8'h60);
        chk("thr_we_cnt", we_cnt - we_base, 3);

        // Full depth with a mid-load start that must be ignored
        tick();
        done_base = done_cnt;
        we_base = we_cnt;
        do_start(4'd15);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            start = (i == 7);
            len   = 4'd1;
            tick();
            chk("full_addr", mem_addr, i);
        end
        start = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("full_done", done, 1);
        chk("full_checksum", checksum, 8'hF0);
        tick();
        tick();
        chk("full_idle_busy", busy, 0);
        chk("full_idle_ready", in_ready, 0);
        chk("full_done_cnt", done_cnt - done_base, 1);
        chk("full_we_cnt", we_cnt - we_base, 16);

        // Reset in the middle of a load
        do_start(4'd3);
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_checksum", checksum, 0);
        #1 reset = 1'b0;
        tick();
        do_start(4'd0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        chk("single_we", mem_we, 1);
        chk("single_addr", mem_addr, 0);
        chk("single_wdata", mem_wdata, 8'h5A);
        tick();
        chk("single_done", done, 1);
        chk("single_checksum", checksum, 8'h5A);
        chk("single_cpu_reset", cpu_reset, 0);
        tick();

`ifdef PROGRAM_LOADER_READBACK_EN
        // Clean readback: done at edge N+6
        do_start(4'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = basic[i];
            tick();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("rb_no_done", done, 0);
            chk("rb_we_low", mem_we, 0);
            if (j < 4) chk("rb_rd_addr", mem_addr, j);
        end
        tick();
        chk("rb_done", done, 1);
        chk("rb_err", err, 0);
        chk("rb_cpu_reset", cpu_reset, 0);
        chk("rb_busy", busy, 0);
        tick();

        // Corrupted readback of address 2
        corrupt = 1'b1;
        do_start(4'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = basic[i];
            tick();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        chk("rbc_done", done, 1);
        chk("rbc_err", err, 1);
        chk("rbc_cpu_reset", cpu_reset, 1);
        chk("rbc_busy", busy, 0);
        tick();
        chk("rbc_err_sticky", err, 1);
        corrupt = 1'b0;
        do_start(4'd0);
        chk("rbc_err_cleared", err, 0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        chk("rb1_done", done, 1);
        chk("rb1_err", err, 0);
        chk("rb1_cpu_reset", cpu_reset, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
